// File: rtl/serializer_lanes.sv
// Word-to-beat serializer: emits a DATA_W-bit word (with valid-bit count) as LANES-bit beats,
// MSB- or LSB-first, under downstream backpressure, with a last-beat marker and drop pulse.
module serializer_lanes #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int DATA_MOD_W = $clog2(DATA_W),
  parameter int LANE_CNT_W = $clog2(LANES) + 1
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [DATA_MOD_W-1:0] data_mod_i,
  input  logic                  data_val_i,
  output logic [LANES-1:0]      ser_data_o,
  output logic [LANE_CNT_W-1:0] ser_lanes_o,
  output logic                  ser_data_val_o,
  output logic                  ser_last_o,
  input  logic                  ser_ready_i,
  output logic                  busy_o,
  output logic                  drop_o,
  output logic                  dbg_state_o
);

  localparam int REM_W = $clog2(DATA_W + 1);
  localparam logic [REM_W-1:0] LANES_R = REM_W'(LANES);

  // Handshake: a beat transfers on any posedge where ser_data_val_o & ser_ready_i are both 1;
  // while ser_ready_i is 0 the beat outputs hold. A word is accepted only when busy_o is 0.
  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     sh_q, sh_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [LANES-1:0]      ser_data_q, ser_data_d;
  logic [LANE_CNT_W-1:0] ser_lanes_q, ser_lanes_d;
  logic                  ser_last_q, ser_last_d;
  logic                  drop_q, drop_d;

  logic [REM_W-1:0]      n_len;
  logic [REM_W-1:0]      cnt;
  logic [LANES-1:0]      raw;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    if (data_mod_i == '0 || int'(data_mod_i) > DATA_W) n_len = REM_W'(DATA_W);
    else                                               n_len = REM_W'(data_mod_i);

    case (state_q)
      S_IDLE: begin
        if (data_val_i) begin
          sh_d    = data_i;
          rem_d   = n_len;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ser_ready_i) begin
          if (rem_q <= LANES_R) begin
            state_d = S_IDLE;
            sh_d    = '0;
            rem_d   = '0;
          end else begin
            sh_d  = (MSB_FIRST != 0) ? (sh_q << LANES) : (sh_q >> LANES);
            rem_d = rem_q - LANES_R;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Beat outputs are precomputed from next state so they leave a flop directly.
    cnt = (rem_d < LANES_R) ? rem_d : LANES_R;
    raw = (MSB_FIRST != 0) ? sh_d[DATA_W-1 -: LANES] : sh_d[LANES-1:0];
    ser_data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (MSB_FIRST != 0) ser_data_d[i] = (i >= LANES - int'(cnt)) ? raw[i] : 1'b0;
      else                ser_data_d[i] = (i < int'(cnt)) ? raw[i] : 1'b0;
    end
    ser_lanes_d = LANE_CNT_W'(cnt);
    ser_last_d  = (state_d == S_SEND) && (rem_d <= LANES_R);
    drop_d      = data_val_i && (state_q == S_SEND);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      rem_q       <= '0;
      ser_data_q  <= '0;
      ser_lanes_q <= '0;
      ser_last_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      rem_q       <= rem_d;
      ser_data_q  <= ser_data_d;
      ser_lanes_q <= ser_lanes_d;
      ser_last_q  <= ser_last_d;
      drop_q      <= drop_d;
    end
  end

  assign ser_data_o     = ser_data_q;
  assign ser_lanes_o    = ser_lanes_q;
  assign ser_last_o     = ser_last_q;
  assign ser_data_val_o = (state_q == S_SEND);
  assign busy_o         = (state_q == S_SEND);
  assign drop_o         = drop_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_serializer_lanes.sv
// Bench for serializer_lanes: eleven configurations share one stimulus stream; each has a
// beat-queue reference model checked every cycle, plus literal checks on chosen configurations.
`timescale 1ns/1ps
module tb_serializer_lanes;

  localparam int NCFG = 11;

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  lanes;
    logic        last;
  } beat_t;

  // clock / reset
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  logic [15:0] data_in;
  logic [3:0]  mod_in;
  logic        val_in;
  logic        ready_in;
  logic        cmp_en = 1'b0;
  logic        cap_en = 1'b0;

  logic [15:0] a_data  [NCFG];
  logic [4:0]  a_lanes [NCFG];
  logic        a_val   [NCFG];
  logic        a_last  [NCFG];
  logic        a_busy  [NCFG];
  logic        a_drop  [NCFG];
  logic        a_dbg   [NCFG];
  beat_t       e_beat  [NCFG];
  logic        e_val   [NCFG];
  logic        e_drop  [NCFG];

  beat_t       cap     [NCFG][$];
  int          drops   [NCFG];
  int          busy_cnt[NCFG];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  // DUT instances and their reference models
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int LN = (g < 10) ? (1 << (g / 2)) : 4;
    localparam int MF = (g < 10) ? (g % 2) : 1;
    localparam int DW = (g < 10) ? 16 : 12;
    localparam int MW = $clog2(DW);
    localparam int CW = $clog2(LN) + 1;

    logic [LN-1:0] sd;
    logic [CW-1:0] sl;
    logic sv, slast, sb, sdrop, sdbg;

    serializer_lanes #(.DATA_W(DW), .LANES(LN), .MSB_FIRST(MF)) u_dut (
      .clk_i         (clk),
      .srst_i        (srst),
      .data_i        (data_in[DW-1:0]),
      .data_mod_i    (mod_in[MW-1:0]),
      .data_val_i    (val_in),
      .ser_data_o    (sd),
      .ser_lanes_o   (sl),
      .ser_data_val_o(sv),
      .ser_last_o    (slast),
      .ser_ready_i   (ready_in),
      .busy_o        (sb),
      .drop_o        (sdrop),
      .dbg_state_o   (sdbg)
    );

    assign a_data[g]  = 16'(sd);
    assign a_lanes[g] = 5'(sl);
    assign a_val[g]   = sv;
    assign a_last[g]  = slast;
    assign a_busy[g]  = sb;
    assign a_drop[g]  = sdrop;
    assign a_dbg[g]   = sdbg;

    // Model: a word becomes a queue of pending beats; the head is what must be on the outputs.
    beat_t q[$];
    beat_t m_beat, bt;
    logic  m_val, m_drop;
    int    n, nb, k, left;

    always @(posedge clk) begin
      if (srst) begin
        q.delete();
        m_drop = 1'b0;
      end else begin
        m_drop = val_in && (q.size() != 0);
        if (q.size() != 0) begin
          if (ready_in) void'(q.pop_front());
        end else if (val_in) begin
          n  = (mod_in == 4'd0 || int'(mod_in) > DW) ? DW : int'(mod_in);
          nb = (n + LN - 1) / LN;
          for (int b = 0; b < nb; b++) begin
            bt = '0;
            for (int j = 0; j < LN; j++) begin
              k = b * LN + j;
              if (k < n) bt.data[(MF != 0) ? LN - 1 - j : j] = data_in[(MF != 0) ? DW - 1 - k : k];
            end
            left     = n - b * LN;
            bt.lanes = 5'((left < LN) ? left : LN);
            bt.last  = (b == nb - 1);
            q.push_back(bt);
          end
        end
      end
      m_val  = (q.size() != 0);
      m_beat = m_val ? q[0] : '0;
    end

    assign e_beat[g] = m_beat;
    assign e_val[g]  = m_val;
    assign e_drop[g] = m_drop;
  end

  // scoreboard: every-cycle compare against the models
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int g = 0; g < NCFG; g++) begin
        chk("data",  g, 32'(a_data[g]),  32'(e_beat[g].data));
        chk("lanes", g, 32'(a_lanes[g]), 32'(e_beat[g].lanes));
        chk("last",  g, 32'(a_last[g]),  32'(e_beat[g].last));
        chk("val",   g, 32'(a_val[g]),   32'(e_val[g]));
        chk("busy",  g, 32'(a_busy[g]),  32'(e_val[g]));
        chk("state", g, 32'(a_dbg[g]),   32'(e_val[g]));
        chk("drop",  g, 32'(a_drop[g]),  32'(e_drop[g]));
      end
    end
  end

  // beat capture for the literal checks
  always @(negedge clk) begin
    if (cap_en) begin
      for (int g = 0; g < NCFG; g++) begin
        if (a_val[g] && ready_in) cap[g].push_back('{data: a_data[g], lanes: a_lanes[g], last: a_last[g]});
        if (a_drop[g]) drops[g]++;
        if (a_busy[g]) busy_cnt[g]++;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic [3:0] m);
    data_in = d;
    mod_in  = m;
    val_in  = 1'b1;
    tick();
    val_in  = 1'b0;
  endtask

  task automatic clear_caps();
    for (int g = 0; g < NCFG; g++) begin
      cap[g].delete();
      drops[g]    = 0;
      busy_cnt[g] = 0;
    end
  endtask

  task automatic wait_idle();
    logic any;
    ready_in = 1'b1;
    any = 1'b1;
    for (int t = 0; t < 400 && any; t++) begin
      any = 1'b0;
      for (int g = 0; g < NCFG; g++) any |= a_busy[g];
      if (any) tick();
    end
    chk("idle_timeout", 0, 32'(any), 32'd0);
  endtask

  task automatic chk_beats(input string nm, input int g, input logic [15:0] d[4],
                           input logic [4:0] l[4], input int nbeats, input int off);
    chk({nm, "_count"}, g, 32'(cap[g].size()), 32'(off + nbeats));
    for (int i = 0; i < nbeats && off + i < cap[g].size(); i++) begin
      chk({nm, "_data"},  g, 32'(cap[g][off+i].data),  32'(d[i]));
      chk({nm, "_lanes"}, g, 32'(cap[g][off+i].lanes), 32'(l[i]));
      chk({nm, "_last"},  g, 32'(cap[g][off+i].last),  32'(i == nbeats - 1));
    end
  endtask

  logic [15:0] word;
  logic [15:0] bd[4];
  logic [4:0]  bl[4];
  int          thr;

  initial begin
    srst = 1'b1; val_in = 1'b0; ready_in = 1'b1; data_in = '0; mod_in = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    for (int g = 0; g < NCFG; g++) begin
      chk("rst_val",  g, 32'(a_val[g]),  32'd0);
      chk("rst_data", g, 32'(a_data[g]), 32'd0);
    end
    srst = 1'b0;
    tick();
    cap_en = 1'b1;

    // legacy-equivalent bit serial, full word
    clear_caps();
    send_word(16'hA5C3, 4'd0);
    wait_idle();
    word = 16'hA5C3;
    chk("t1_count", 1, 32'(cap[1].size()), 32'd16);
    for (int i = 0; i < 16 && i < cap[1].size(); i++) begin
      chk("t1_bit",  1, 32'(cap[1][i].data), 32'(word[15-i]));
      chk("t1_last", 1, 32'(cap[1][i].last), 32'(i == 15));
    end
    chk("t1_busy_cycles", 1, 32'(busy_cnt[1]), 32'd16);

    // partial last beat, both bit orders
    clear_caps();
    send_word(16'h1234, 4'd10);
    wait_idle();
    bd = '{16'h1, 16'h2, 16'h0, 16'h0}; bl = '{5'd4, 5'd4, 5'd2, 5'd0};
    chk_beats("t2_msb", 5, bd, bl, 3, 0);
    bd = '{16'h4, 16'h3, 16'h2, 16'h0};
    chk_beats("t2_lsb", 4, bd, bl, 3, 0);

    // backpressure with random ready
    clear_caps();
    send_word(16'hBEEF, 4'd0);
    for (int i = 0; i < 40; i++) begin
      ready_in = 1'($urandom_range(0, 1));
      tick();
    end
    wait_idle();
    bd = '{16'hB, 16'hE, 16'hE, 16'hF}; bl = '{5'd4, 5'd4, 5'd4, 5'd4};
    chk_beats("t3", 5, bd, bl, 4, 0);

    // drop while busy, then a clean follow-up word
    clear_caps();
    send_word(16'h1357, 4'd0);
    tick();
    send_word(16'hFFFF, 4'd0);
    wait_idle();
    chk("t4_drops", 5, 32'(drops[5]), 32'd1);
    bd = '{16'h1, 16'h3, 16'h5, 16'h7};
    chk_beats("t4_first", 5, bd, bl, 4, 0);
    send_word(16'h2468, 4'd0);
    wait_idle();
    bd = '{16'h2, 16'h4, 16'h6, 16'h8};
    chk_beats("t4_next", 5, bd, bl, 4, 4);

    // reset mid-word
    clear_caps();
    send_word(16'hCAFE, 4'd0);
    tick();
    tick();
    srst = 1'b1; ready_in = 1'b0;
    tick();
    chk("t5_val",   5, 32'(a_val[5]),   32'd0);
    chk("t5_busy",  5, 32'(a_busy[5]),  32'd0);
    chk("t5_data",  5, 32'(a_data[5]),  32'd0);
    chk("t5_lanes", 5, 32'(a_lanes[5]), 32'd0);
    chk("t5_beats", 5, 32'(cap[5].size()), 32'd2);
    for (int i = 0; i < cap[5].size(); i++) chk("t5_nolast", 5, 32'(cap[5][i].last), 32'd0);
    srst = 1'b0; ready_in = 1'b1;
    tick();
    clear_caps();
    send_word(16'h00FF, 4'd0);
    wait_idle();
    bd = '{16'h0, 16'h0, 16'hF, 16'hF};
    chk_beats("t5_after", 5, bd, bl, 4, 0);

    // count clamp on a non-power-of-two width
    clear_caps();
    send_word(16'h0ABC, 4'd15);
    wait_idle();
    bd = '{16'hA, 16'hB, 16'hC, 16'h0};
    chk_beats("t6_clamp", 10, bd, bl, 3, 0);

    // random regression
    for (int c = 0; c < 45000; c++) begin
      if (c % 1000 == 0) thr = (c / 1000 % 3 == 0) ? 100 : (c / 1000 % 3 == 1) ? 50 : 20;
      val_in   = ($urandom_range(0, 3) == 0);
      data_in  = 16'($urandom);
      mod_in   = 4'($urandom_range(0, 15));
      ready_in = ($urandom_range(0, 99) < thr);
      srst     = ($urandom_range(0, 999) == 0);
      tick();
    end
    val_in = 1'b0;
    srst   = 1'b0;
    wait_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
